// File: rtl/sample_mem_ctrl.sv
// Purpose : single-port sample memory controller; single-word writes and wrapping burst reads.
// Latency : read beat 0 appears WAIT_CYCLES+2 edges after acceptance, ack one edge after last beat.
// Backpr. : no queuing; req is sampled only in IDLE and ignored while busy.
module sample_mem_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 21,
  parameter int WAIT_CYCLES = 3,
  parameter int MAX_BURST   = 8
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        burst_len,
  output logic              busy,
  output logic              CE,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              ack
);

  // Wait counter only has to count 0..WAIT_CYCLES-1; keep at least one bit.
  localparam int WCNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WAIT  = 3'd2,
    XFER  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Storage: never reset, contents undefined after power-up.
  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  state_t            state_q,    state_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic              we_q,       we_d;
  logic [3:0]        len_q,      len_d;
  logic [3:0]        beat_cnt_q, beat_cnt_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              busy_q,     busy_d;
  logic              ce_q,       ce_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;
  logic              ack_q,      ack_d;
  logic              mem_wr_en;

  // Clamp the requested beat count: 0 means one beat, anything above MAX_BURST saturates.
  function automatic logic [3:0] eff_len(input logic [3:0] bl);
    if (bl == 4'd0) begin
      return 4'd1;
    end else if (bl > 4'(MAX_BURST)) begin
      return 4'(MAX_BURST);
    end else begin
      return bl;
    end
  endfunction

  // Next-state, counters and registered outputs. Outputs are derived from the current
  // state, so every output trails the state register by exactly one edge.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    mem_wr_en  = 1'b0;
    busy_d     = (state_q != IDLE);
    ce_d       = (state_q == SETUP) || (state_q == WAIT) || (state_q == XFER);
    ack_d      = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = SETUP;
          addr_d     = addr;
          wdata_d    = wdata;
          we_d       = we;
          // A write is always a single transfer cycle regardless of burst_len.
          len_d      = we ? 4'd1 : eff_len(burst_len);
          beat_cnt_d = 4'd0;
          wait_cnt_d = '0;
        end
      end
      SETUP: begin
        if (WAIT_CYCLES == 0) begin
          state_d = XFER;
        end else begin
          state_d    = WAIT;
          wait_cnt_d = '0;
        end
      end
      WAIT: begin
        if (wait_cnt_q == WCNT_W'(WAIT_CYCLES - 1)) begin
          state_d    = XFER;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      XFER: begin
        if (we_q) begin
          mem_wr_en = 1'b1;
        end else begin
          rd_valid_d = 1'b1;
          rdata_d    = mem[addr_q];
          // Address counter is ADDR_W wide, so it wraps at the top of memory.
          addr_d     = addr_q + ADDR_W'(1);
        end
        if (beat_cnt_q == len_q - 4'd1) begin
          state_d    = DONE;
          beat_cnt_d = 4'd0;
        end else begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request latches, counters and outputs; reset aborts any access in flight.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      len_q      <= 4'd0;
      beat_cnt_q <= 4'd0;
      wait_cnt_q <= '0;
      busy_q     <= 1'b0;
      ce_q       <= 1'b0;
      rd_valid_q <= 1'b0;
      rdata_q    <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      busy_q     <= busy_d;
      ce_q       <= ce_d;
      rd_valid_q <= rd_valid_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
    end
  end

  // Write commit at the end of the XFER cycle; reset drops the state so an
  // uncommitted write is simply lost.
  always_ff @(posedge CLK) begin
    if (mem_wr_en) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign busy     = busy_q;
  assign CE       = ce_q;
  assign rd_valid = rd_valid_q;
  assign rdata    = rdata_q;
  assign ack      = ack_q;

endmodule

// File: tb/tb_sample_mem_ctrl.sv
// Bench for sample_mem_ctrl: a WAIT_CYCLES=3 instance and a WAIT_CYCLES=0 instance share
// stimulus; sel routes req to one of them and selects whose outputs are observed.
// Expected read data lives in a scoreboard queue, popped on every rd_valid beat.
module tb_sample_mem_ctrl;
  localparam int DW = 32;
  localparam int AW = 8;

  logic          CLK = 1'b0;
  logic          rst_n;
  logic          req, we, sel;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    burst_len;

  logic          req3, req0;
  logic          busy3, ce3, rv3, ack3;
  logic          busy0, ce0, rv0, ack0;
  logic [DW-1:0] rd3, rd0;
  logic          o_busy, o_ce, o_rv, o_ack;
  logic [DW-1:0] o_rd;

  always #5 CLK = ~CLK;

  assign req3   = req & ~sel;
  assign req0   = req & sel;
  assign o_busy = sel ? busy0 : busy3;
  assign o_ce   = sel ? ce0   : ce3;
  assign o_rv   = sel ? rv0   : rv3;
  assign o_ack  = sel ? ack0  : ack3;
  assign o_rd   = sel ? rd0   : rd3;

  sample_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(3), .MAX_BURST(8)) dut (
    .CLK(CLK), .rst_n(rst_n), .req(req3), .we(we), .addr(addr), .wdata(wdata),
    .burst_len(burst_len), .busy(busy3), .CE(ce3), .rd_valid(rv3), .rdata(rd3), .ack(ack3)
  );

  sample_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(0), .MAX_BURST(8)) dut0 (
    .CLK(CLK), .rst_n(rst_n), .req(req0), .we(we), .addr(addr), .wdata(wdata),
    .burst_len(burst_len), .busy(busy0), .CE(ce0), .rd_valid(rv0), .rdata(rd0), .ack(ack0)
  );

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  int            rv_cnt, rv_first, rv_last, ack_cnt, ack_first, ce_cnt, ce_first, ce_last;
  logic          busy_log [0:63];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    rv_cnt = 0; rv_first = -1; rv_last = -1;
    ack_cnt = 0; ack_first = -1;
    ce_cnt = 0; ce_first = -1; ce_last = -1;
    for (int i = 0; i < 64; i++) busy_log[i] = 1'b0;
  endtask

  // Present a request and let the next rising edge accept it (edge N).
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] bl);
    we = w; addr = a; wdata = d; burst_len = bl; req = 1'b1;
    @(posedge CLK);
    #1 req = 1'b0;
  endtask

  // Sample at the falling edge after edges N+k0 .. N+k0+n-1. req is driven high
  // for edges N+req_from+1 .. N+req_to when req_to > req_from.
  task automatic observe(input int k0, input int n, input int req_from, input int req_to);
    for (int k = k0; k < k0 + n; k++) begin
      @(negedge CLK);
      if (o_rv) begin
        if (rv_first < 0) rv_first = k;
        rv_last = k;
        rv_cnt++;
        if (exp_q.size() != 0) chk("beat_data", o_rd, exp_q.pop_front());
      end
      if (o_ack) begin
        if (ack_first < 0) ack_first = k;
        ack_cnt++;
      end
      if (o_ce) begin
        if (ce_first < 0) ce_first = k;
        ce_last = k;
        ce_cnt++;
      end
      if (k < 64) busy_log[k] = o_busy;
      if (req_to > req_from) req = (k >= req_from && k < req_to);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    clear_stats();
    issue(1'b1, a, d, 4'd0);
    observe(0, 8, 0, 0);
    chk("preload_ack", 64'(ack_cnt), 64'd1);
    chk("preload_no_beat", 64'(rv_cnt), 64'd0);
  endtask

  initial begin
    logic [AW-1:0] a;
    sel = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; burst_len = 4'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_ce", 64'(o_ce), 64'd0);
    chk("rst_rd_valid", 64'(o_rv), 64'd0);
    chk("rst_ack", 64'(o_ack), 64'd0);
    chk("rst_rdata", 64'(o_rd), 64'd0);
    @(negedge CLK) rst_n = 1'b1;

    // Write 0xDEADBEEF to 0x10; burst_len must be ignored.
    clear_stats();
    issue(1'b1, 8'h10, 32'hDEADBEEF, 4'd9);
    observe(0, 5, 0, 0);
    chk("wr_mem_before_commit", 64'(dut.mem[8'h10] !== 32'hDEADBEEF), 64'd1);
    observe(5, 4, 0, 0);
    chk("wr_mem_after_commit", 64'(dut.mem[8'h10]), 64'hDEADBEEF);
    chk("wr_ack_cnt", 64'(ack_cnt), 64'd1);
    chk("wr_ack_edge", 64'(ack_first), 64'd6);
    chk("wr_no_beat", 64'(rv_cnt), 64'd0);
    chk("wr_ce_first", 64'(ce_first), 64'd1);
    chk("wr_ce_last", 64'(ce_last), 64'd5);
    chk("wr_busy_edge6", 64'(busy_log[6]), 64'd1);
    chk("wr_busy_edge7", 64'(busy_log[7]), 64'd0);

    // Read it back, single beat.
    clear_stats();
    exp_q.push_back(32'hDEADBEEF);
    issue(1'b0, 8'h10, '0, 4'd1);
    observe(0, 10, 0, 0);
    chk("rdback_beats", 64'(rv_cnt), 64'd1);
    chk("rdback_edge", 64'(rv_first), 64'd5);
    chk("rdback_left", 64'(exp_q.size()), 64'd0);

    // Burst read of 0x20..0x23.
    for (int i = 0; i < 4; i++) do_write(8'h20 + 8'(i), 32'(i + 1));
    clear_stats();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 1));
    issue(1'b0, 8'h20, '0, 4'd4);
    observe(0, 12, 0, 0);
    chk("burst_beats", 64'(rv_cnt), 64'd4);
    chk("burst_first", 64'(rv_first), 64'd5);
    chk("burst_last", 64'(rv_last), 64'd8);
    chk("burst_ack_cnt", 64'(ack_cnt), 64'd1);
    chk("burst_ack_edge", 64'(ack_first), 64'd9);
    chk("burst_ce_cnt", 64'(ce_cnt), 64'd8);
    chk("burst_ce_first", 64'(ce_first), 64'd1);
    chk("burst_ce_last", 64'(ce_last), 64'd8);
    chk("burst_busy_edge9", 64'(busy_log[9]), 64'd1);
    chk("burst_busy_edge10", 64'(busy_log[10]), 64'd0);
    chk("burst_left", 64'(exp_q.size()), 64'd0);

    // Wrap at top of memory with burst_len clamped from 12 to 8.
    for (int i = 0; i < 8; i++) begin
      a = 8'hFE + 8'(i);
      do_write(a, 32'hA500 + 32'(i));
    end
    clear_stats();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'hA500 + 32'(i));
    issue(1'b0, 8'hFE, '0, 4'd12);
    observe(0, 16, 0, 0);
    chk("wrap_beats", 64'(rv_cnt), 64'd8);
    chk("wrap_last", 64'(rv_last), 64'd12);
    chk("wrap_left", 64'(exp_q.size()), 64'd0);

    // burst_len = 0 gives one beat.
    clear_stats();
    exp_q.push_back(32'hA507);
    issue(1'b0, 8'h05, '0, 4'd0);
    observe(0, 10, 0, 0);
    chk("len0_beats", 64'(rv_cnt), 64'd1);
    chk("len0_left", 64'(exp_q.size()), 64'd0);

    // Write request raised while a read is active must be dropped.
    clear_stats();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i + 1));
    issue(1'b0, 8'h20, '0, 4'd4);
    we = 1'b1; addr = 8'h21; wdata = 32'h55;
    observe(0, 14, 2, 7);
    chk("coll_ack_cnt", 64'(ack_cnt), 64'd1);
    chk("coll_beats", 64'(rv_cnt), 64'd4);
    chk("coll_left", 64'(exp_q.size()), 64'd0);
    clear_stats();
    exp_q.push_back(32'd2);
    issue(1'b0, 8'h21, '0, 4'd1);
    observe(0, 10, 0, 0);
    chk("coll_unchanged_beats", 64'(rv_cnt), 64'd1);
    chk("coll_unchanged_left", 64'(exp_q.size()), 64'd0);

    // req held high: two back-to-back reads separated by DONE and one IDLE cycle.
    clear_stats();
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd1);
    issue(1'b0, 8'h20, '0, 4'd1);
    observe(0, 16, 0, 7);
    chk("b2b_beats", 64'(rv_cnt), 64'd2);
    chk("b2b_first", 64'(rv_first), 64'd5);
    chk("b2b_second", 64'(rv_last), 64'd12);
    chk("b2b_acks", 64'(ack_cnt), 64'd2);
    chk("b2b_left", 64'(exp_q.size()), 64'd0);

    // Reset after the second beat of an 8-beat read.
    clear_stats();
    exp_q.push_back(32'hA500);
    exp_q.push_back(32'hA501);
    issue(1'b0, 8'hFE, '0, 4'd8);
    observe(0, 7, 0, 0);
    chk("rstmid_beats_before", 64'(rv_cnt), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 64'(o_busy), 64'd0);
    chk("rstmid_ce", 64'(o_ce), 64'd0);
    chk("rstmid_rd_valid", 64'(o_rv), 64'd0);
    chk("rstmid_ack", 64'(o_ack), 64'd0);
    chk("rstmid_rdata", 64'(o_rd), 64'd0);
    @(negedge CLK);
    @(negedge CLK) rst_n = 1'b1;
    clear_stats();
    observe(0, 10, 0, 0);
    chk("rstmid_no_beat", 64'(rv_cnt), 64'd0);
    chk("rstmid_no_ack", 64'(ack_cnt), 64'd0);
    clear_stats();
    exp_q.push_back(32'hDEADBEEF);
    issue(1'b0, 8'h10, '0, 4'd1);
    observe(0, 10, 0, 0);
    chk("rstmid_next_edge", 64'(rv_first), 64'd5);
    chk("rstmid_next_ack", 64'(ack_first), 64'd6);
    chk("rstmid_left", 64'(exp_q.size()), 64'd0);

    // Write aborted by reset before its commit edge; first edge after release accepts.
    do_write(8'h30, 32'h1111);
    clear_stats();
    issue(1'b1, 8'h30, 32'h2222, 4'd0);
    observe(0, 3, 0, 0);
    #1 rst_n = 1'b0;
    @(negedge CLK) rst_n = 1'b1;
    clear_stats();
    exp_q.push_back(32'h1111);
    issue(1'b0, 8'h30, '0, 4'd1);
    observe(0, 10, 0, 0);
    chk("abort_wr_edge", 64'(rv_first), 64'd5);
    chk("abort_wr_beats", 64'(rv_cnt), 64'd1);
    chk("abort_wr_left", 64'(exp_q.size()), 64'd0);

    // Zero wait-state build.
    sel = 1'b1;
    do_write(8'h40, 32'hC0DE0000);
    do_write(8'h41, 32'hC0DE0001);
    clear_stats();
    exp_q.push_back(32'hC0DE0000);
    exp_q.push_back(32'hC0DE0001);
    issue(1'b0, 8'h40, '0, 4'd2);
    observe(0, 8, 0, 0);
    chk("ws0_first", 64'(rv_first), 64'd2);
    chk("ws0_last", 64'(rv_last), 64'd3);
    chk("ws0_beats", 64'(rv_cnt), 64'd2);
    chk("ws0_ack_edge", 64'(ack_first), 64'd4);
    chk("ws0_ack_cnt", 64'(ack_cnt), 64'd1);
    chk("ws0_left", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
